// File: rtl/pipe_stage_fwd.sv
// Decode/issue pipeline register with operand forwarding, load-use stall
// detection and hold-time snooping of late forwarding results.
module pipe_stage_fwd #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NSRC  = 2,
   parameter int unsigned NFWD  = 2,
   parameter int unsigned CTRLW = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [CTRLW-1:0]       in_ctrl,
   input  logic [XLEN-1:0]        in_pc,
   input  logic [XLEN-1:0]        in_imm,
   input  logic [4:0]             in_rd,
   input  logic [NSRC*5-1:0]      in_rs_addr,
   input  logic [NSRC*XLEN-1:0]   in_rs_data,
   input  logic [NFWD-1:0]        fwd_en,
   input  logic [NFWD*5-1:0]      fwd_rd,
   input  logic [NFWD*XLEN-1:0]   fwd_data,
   input  logic [NFWD-1:0]        fwd_rdy,
   input  logic                   flush,
   input  logic                   hold,
   output logic                   out_valid,
   output logic [CTRLW-1:0]       out_ctrl,
   output logic [XLEN-1:0]        out_pc,
   output logic [XLEN-1:0]        out_imm,
   output logic [4:0]             out_rd,
   output logic [NSRC*XLEN-1:0]   out_rs_data,
   output logic                   stall_req
);

   localparam int unsigned AW = 5;
   localparam int unsigned LW = XLEN + 2;

   // Returns {hit, rdy, data} for the youngest source writing addr; x0 never hits.
   function automatic logic [LW-1:0] fwd_lookup(
      input logic [AW-1:0]        addr,
      input logic [NFWD-1:0]      en,
      input logic [NFWD*AW-1:0]   rd,
      input logic [NFWD-1:0]      rdy,
      input logic [NFWD*XLEN-1:0] data
   );
      logic [LW-1:0] r;
      r = '0;
      for (int j = int'(NFWD) - 1; j >= 0; j--) begin
         if (en[j] && (addr != '0) && (rd[j*AW +: AW] == addr)) begin
            r = {1'b1, rdy[j], data[j*XLEN +: XLEN]};
         end
      end
      return r;
   endfunction

   logic                 valid_q,   valid_d;
   logic [CTRLW-1:0]     ctrl_q,    ctrl_d;
   logic [XLEN-1:0]      pc_q,      pc_d;
   logic [XLEN-1:0]      imm_q,     imm_d;
   logic [AW-1:0]        rd_q,      rd_d;
   logic [NSRC*XLEN-1:0] rs_data_q, rs_data_d;
   logic [NSRC*AW-1:0]   rs_addr_q, rs_addr_d;

   logic [LW-1:0]        in_look  [NSRC];
   logic [LW-1:0]        snp_look [NSRC];
   logic [NSRC*XLEN-1:0] res_data;
   logic [NSRC*XLEN-1:0] snoop_data;
   logic [NSRC-1:0]      res_pend;

   for (genvar g = 0; g < int'(NSRC); g++) begin : g_look
      assign in_look[g]  = fwd_lookup(in_rs_addr[g*AW +: AW], fwd_en, fwd_rd, fwd_rdy, fwd_data);
      assign snp_look[g] = fwd_lookup(rs_addr_q[g*AW +: AW], fwd_en, fwd_rd, fwd_rdy, fwd_data);
   end

   // Resolved operands for a fresh load, and snooped operands for a held one.
   always_comb begin
      res_data   = in_rs_data;
      snoop_data = rs_data_q;
      res_pend   = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (in_look[i][XLEN+1]) begin
            res_data[i*XLEN +: XLEN] = in_look[i][XLEN-1:0];
            res_pend[i]              = ~in_look[i][XLEN];
         end
         if (snp_look[i][XLEN+1] && snp_look[i][XLEN]) begin
            snoop_data[i*XLEN +: XLEN] = snp_look[i][XLEN-1:0];
         end
      end
   end

   assign stall_req = in_valid & ~flush & (|res_pend);

   // Next-state selection: flush > hold > stall bubble > normal load.
   always_comb begin
      valid_d   = valid_q;
      ctrl_d    = ctrl_q;
      pc_d      = pc_q;
      imm_d     = imm_q;
      rd_d      = rd_q;
      rs_data_d = rs_data_q;
      rs_addr_d = rs_addr_q;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         rd_d    = '0;
      end else if (hold) begin
         rs_data_d = snoop_data;
      end else if (stall_req) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         rd_d    = '0;
      end else begin
         valid_d   = in_valid;
         ctrl_d    = in_valid ? in_ctrl : '0;
         pc_d      = in_pc;
         imm_d     = in_imm;
         rd_d      = in_rd;
         rs_data_d = res_data;
         rs_addr_d = in_rs_addr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         pc_q      <= '0;
         imm_q     <= '0;
         rd_q      <= '0;
         rs_data_q <= '0;
         rs_addr_q <= '0;
      end else begin
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         pc_q      <= pc_d;
         imm_q     <= imm_d;
         rd_q      <= rd_d;
         rs_data_q <= rs_data_d;
         rs_addr_q <= rs_addr_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_ctrl    = ctrl_q;
   assign out_pc      = pc_q;
   assign out_imm     = imm_q;
   assign out_rd      = rd_q;
   assign out_rs_data = rs_data_q;

endmodule

// File: tb/tb_pipe_stage_fwd.sv
// Bench for pipe_stage_fwd: directed scenarios plus randomized traffic checked
// against a behavioural model of the stage.
module tb_pipe_stage_fwd;

   localparam int XLEN  = 32;
   localparam int NSRC  = 2;
   localparam int NFWD  = 2;
   localparam int CTRLW = 16;

   logic                 clk;
   logic                 reset;
   logic                 in_valid;
   logic [CTRLW-1:0]     in_ctrl;
   logic [XLEN-1:0]      in_pc, in_imm;
   logic [4:0]           in_rd;
   logic [NSRC*5-1:0]    in_rs_addr;
   logic [NSRC*XLEN-1:0] in_rs_data;
   logic [NFWD-1:0]      fwd_en;
   logic [NFWD*5-1:0]    fwd_rd;
   logic [NFWD*XLEN-1:0] fwd_data;
   logic [NFWD-1:0]      fwd_rdy;
   logic                 flush, hold;
   logic                 out_valid;
   logic [CTRLW-1:0]     out_ctrl;
   logic [XLEN-1:0]      out_pc, out_imm;
   logic [4:0]           out_rd;
   logic [NSRC*XLEN-1:0] out_rs_data;
   logic                 stall_req;

   pipe_stage_fwd #(.XLEN(XLEN), .NSRC(NSRC), .NFWD(NFWD), .CTRLW(CTRLW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
      .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd), .in_rs_addr(in_rs_addr),
      .in_rs_data(in_rs_data), .fwd_en(fwd_en), .fwd_rd(fwd_rd),
      .fwd_data(fwd_data), .fwd_rdy(fwd_rdy), .flush(flush), .hold(hold),
      .out_valid(out_valid), .out_ctrl(out_ctrl), .out_pc(out_pc),
      .out_imm(out_imm), .out_rd(out_rd), .out_rs_data(out_rs_data),
      .stall_req(stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model of the stage contents; m_dc marks pc/imm/operands as unspecified.
   logic             m_valid;
   logic [CTRLW-1:0] m_ctrl;
   logic [XLEN-1:0]  m_pc, m_imm;
   logic [4:0]       m_rd;
   logic [XLEN-1:0]  m_data [NSRC];
   logic [4:0]       m_addr [NSRC];
   logic             m_dc;

   function automatic int first_producer(input logic [4:0] a);
      for (int j = 0; j < NFWD; j++)
         if (fwd_en[j] && a != 5'd0 && fwd_rd[j*5 +: 5] == a) return j;
      return -1;
   endfunction

   function automatic logic exp_stall();
      logic s = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         int p = first_producer(in_rs_addr[i*5 +: 5]);
         if (p >= 0 && !fwd_rdy[p]) s = 1'b1;
      end
      return in_valid && !flush && s;
   endfunction

   function automatic void model_reset();
      m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_imm = '0; m_rd = '0; m_dc = 1'b0;
      for (int i = 0; i < NSRC; i++) begin m_data[i] = '0; m_addr[i] = '0; end
   endfunction

   function automatic void model_clock();
      if (!reset) return;
      if (flush) begin
         m_valid = 1'b0; m_ctrl = '0; m_rd = '0; m_dc = 1'b1;
      end else if (hold) begin
         if (!m_dc)
            for (int i = 0; i < NSRC; i++) begin
               int p = first_producer(m_addr[i]);
               if (p >= 0 && fwd_rdy[p]) m_data[i] = fwd_data[p*XLEN +: XLEN];
            end
      end else if (exp_stall()) begin
         m_valid = 1'b0; m_ctrl = '0; m_rd = '0; m_dc = 1'b1;
      end else begin
         m_valid = in_valid;
         m_ctrl  = in_valid ? in_ctrl : '0;
         m_pc = in_pc; m_imm = in_imm; m_rd = in_rd; m_dc = 1'b0;
         for (int i = 0; i < NSRC; i++) begin
            int p = first_producer(in_rs_addr[i*5 +: 5]);
            m_addr[i] = in_rs_addr[i*5 +: 5];
            m_data[i] = (p >= 0) ? fwd_data[p*XLEN +: XLEN] : in_rs_data[i*XLEN +: XLEN];
         end
      end
   endfunction

   task automatic tick();
      model_clock();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid = 0; in_ctrl = '0; in_pc = '0; in_imm = '0; in_rd = '0;
      in_rs_addr = '0; in_rs_data = '0; fwd_en = '0; fwd_rd = '0;
      fwd_data = '0; fwd_rdy = '0; flush = 0; hold = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_inputs();
      model_reset();
      #12;
      n_vec++;
      if ({out_valid, out_ctrl, out_pc, out_imm, out_rd, out_rs_data} !== '0) begin
         n_err++; $display("FAIL reset_outputs: got valid=%0b ctrl=%h pc=%h rd=%0d, want all 0", out_valid, out_ctrl, out_pc, out_rd);
      end
      reset = 1'b1;
      in_valid = 1; in_ctrl = 16'h1234; in_pc = 32'h400; in_rd = 5'd3;
      tick();
      n_vec++;
      if ({out_valid, out_ctrl, out_pc, out_rd} !== {1'b1, 16'h1234, 32'h400, 5'd3}) begin
         n_err++; $display("FAIL first_load: got valid=%0b ctrl=%h pc=%h rd=%0d, want 1/1234/400/3", out_valid, out_ctrl, out_pc, out_rd);
      end
   endtask

   task automatic test_youngest_wins();
      clear_inputs();
      in_valid = 1; in_rs_addr[4:0] = 5'd5; in_rs_data[31:0] = 32'h11;
      fwd_en = 2'b11; fwd_rdy = 2'b11; fwd_rd = {5'd5, 5'd5};
      fwd_data = {32'hBB, 32'hAA};
      tick();
      n_vec++;
      if (out_rs_data[31:0] !== 32'hAA) begin
         n_err++; $display("FAIL youngest_wins: got %h want 000000aa", out_rs_data[31:0]);
      end
   endtask

   task automatic test_x0_never_forwards();
      clear_inputs();
      in_valid = 1; in_rs_addr = {5'd0, 5'd3}; in_rs_data = {32'h0, 32'h33};
      fwd_en = 2'b01; fwd_rdy = 2'b01; fwd_rd = {5'd0, 5'd0}; fwd_data = {32'h0, 32'hFF};
      tick();
      n_vec++;
      if (out_rs_data !== {32'h0, 32'h33}) begin
         n_err++; $display("FAIL x0_no_fwd: got %h want 0000000000000033", out_rs_data);
      end
   endtask

   task automatic test_load_use();
      clear_inputs();
      in_valid = 1; in_ctrl = 16'h00C3; in_rs_addr[4:0] = 5'd7; in_rs_data[31:0] = 32'h5;
      fwd_en = 2'b01; fwd_rd[4:0] = 5'd7; fwd_rdy = 2'b00;
      #1;
      n_vec++;
      if (stall_req !== 1'b1) begin
         n_err++; $display("FAIL load_use_stall: got %0b want 1", stall_req);
      end
      tick();
      n_vec++;
      if ({out_valid, out_ctrl, out_rd} !== '0) begin
         n_err++; $display("FAIL load_use_bubble: got valid=%0b ctrl=%h rd=%0d want 0", out_valid, out_ctrl, out_rd);
      end
      fwd_en = 2'b10; fwd_rd = {5'd7, 5'd0}; fwd_rdy = 2'b10; fwd_data = {32'h42, 32'h0};
      #1;
      n_vec++;
      if (stall_req !== 1'b0) begin
         n_err++; $display("FAIL load_use_release: got %0b want 0", stall_req);
      end
      tick();
      n_vec++;
      if ({out_valid, out_rs_data[31:0]} !== {1'b1, 32'h42}) begin
         n_err++; $display("FAIL load_use_fwd: got valid=%0b op0=%h want 1/00000042", out_valid, out_rs_data[31:0]);
      end
   endtask

   task automatic test_hold_snoop();
      clear_inputs();
      in_valid = 1; in_pc = 32'h1000; in_rs_addr[4:0] = 5'd9; in_rs_data[31:0] = 32'h99;
      tick();
      hold = 1; in_pc = 32'h2000; in_rs_addr[4:0] = 5'd1;
      tick();
      n_vec++;
      if ({out_pc, out_rs_data[31:0]} !== {32'h1000, 32'h99}) begin
         n_err++; $display("FAIL hold_c1: got pc=%h op0=%h want 00001000/00000099", out_pc, out_rs_data[31:0]);
      end
      fwd_en = 2'b10; fwd_rd = {5'd9, 5'd0}; fwd_rdy = 2'b10; fwd_data = {32'h77, 32'h0};
      tick();
      fwd_en = 2'b00;
      tick();
      n_vec++;
      if ({out_valid, out_pc, out_rs_data[31:0]} !== {1'b1, 32'h1000, 32'h77}) begin
         n_err++; $display("FAIL hold_snoop: got valid=%0b pc=%h op0=%h want 1/00001000/00000077", out_valid, out_pc, out_rs_data[31:0]);
      end
   endtask

   task automatic test_flush_over_hold();
      clear_inputs();
      in_valid = 1; in_ctrl = 16'hBEEF; in_rd = 5'd12;
      tick();
      flush = 1; hold = 1;
      tick();
      n_vec++;
      if ({out_valid, out_ctrl, out_rd} !== '0) begin
         n_err++; $display("FAIL flush_hold: got valid=%0b ctrl=%h rd=%0d want 0", out_valid, out_ctrl, out_rd);
      end
   endtask

   task automatic test_reset_mid_hold();
      clear_inputs();
      in_valid = 1; in_ctrl = 16'h0F0F; in_pc = 32'hABC; in_imm = 32'h7; in_rd = 5'd4;
      in_rs_addr = {5'd2, 5'd6}; in_rs_data = {32'h22, 32'h66};
      tick();
      hold = 1;
      tick();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if ({out_valid, out_ctrl, out_pc, out_imm, out_rd, out_rs_data} !== '0) begin
         n_err++; $display("FAIL reset_mid_hold: got valid=%0b ctrl=%h pc=%h ops=%h want all 0", out_valid, out_ctrl, out_pc, out_rs_data);
      end
      clear_inputs();
      #3;
      reset = 1'b1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid   = ($urandom_range(0, 4) != 0);
         in_ctrl    = CTRLW'($urandom);
         in_pc      = $urandom;
         in_imm     = $urandom;
         in_rd      = 5'($urandom_range(0, 31));
         for (int i = 0; i < NSRC; i++) begin
            in_rs_addr[i*5 +: 5]    = 5'($urandom_range(0, 3));
            in_rs_data[i*XLEN +: XLEN] = $urandom;
         end
         for (int j = 0; j < NFWD; j++) begin
            fwd_rd[j*5 +: 5]        = 5'($urandom_range(0, 3));
            fwd_data[j*XLEN +: XLEN] = $urandom;
         end
         fwd_en  = NFWD'($urandom);
         fwd_rdy = NFWD'($urandom) | NFWD'($urandom);
         flush   = ($urandom_range(0, 9) == 0);
         hold    = ($urandom_range(0, 4) == 0);
         #1;
         n_vec++;
         if (stall_req !== exp_stall()) begin
            n_err++; $display("FAIL rnd_stall c=%0d: got %0b want %0b", c, stall_req, exp_stall());
         end
         tick();
         n_vec++;
         if ({out_valid, out_ctrl, out_rd} !== {m_valid, m_ctrl, m_rd}) begin
            n_err++; $display("FAIL rnd_ctl c=%0d: got %0b/%h/%0d want %0b/%h/%0d", c, out_valid, out_ctrl, out_rd, m_valid, m_ctrl, m_rd);
         end
         if (!m_dc) begin
            n_vec++;
            if ({out_pc, out_imm} !== {m_pc, m_imm}) begin
               n_err++; $display("FAIL rnd_pc c=%0d: got %h/%h want %h/%h", c, out_pc, out_imm, m_pc, m_imm);
            end
            for (int i = 0; i < NSRC; i++) begin
               n_vec++;
               if (out_rs_data[i*XLEN +: XLEN] !== m_data[i]) begin
                  n_err++; $display("FAIL rnd_op%0d c=%0d: got %h want %h", i, c, out_rs_data[i*XLEN +: XLEN], m_data[i]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_youngest_wins();
      test_x0_never_forwards();
      test_load_use();
      test_hold_snoop();
      test_flush_over_hold();
      test_reset_mid_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_fwd.md
PIPE_STAGE_FWD -- requirements
Module: pipe_stage_fwd

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter NSRC, default 2, number of source operands (1..4).
REQ-003 Parameter NFWD, default 2, number of forwarding sources; index 0 is youngest (EX), higher indices are older (MEM, WB...).
REQ-004 Parameter CTRLW, default 16, width of opaque control bundle.
REQ-005 The reset is reset, asynchronous, active-low; the clock is clk.
REQ-006 Port clk  in  1  clock, rising edge.
REQ-007 Port reset  in  1  asynchronous active-low reset.
REQ-008 Port in_valid  in  1  upstream instruction valid.
REQ-009 Port in_ctrl  in  CTRLW  decoded control bundle.
REQ-010 Port in_pc, in_imm  in  XLEN each  PC and sign-extended immediate.
REQ-011 Port in_rd  in  5  destination register address.
REQ-012 Port in_rs_addr  in  NSRC*5  source register addresses, operand i at [5i+4:5i].
REQ-013 Port in_rs_data  in  NSRC*XLEN  register-file read data.
REQ-014 Port fwd_en  in  NFWD  forwarding source j will write a register.
REQ-015 Port fwd_rd  in  NFWD*5  forwarding source destination addresses.
REQ-016 Port fwd_data  in  NFWD*XLEN  forwarding source result values.
REQ-017 Port fwd_rdy  in  NFWD  fwd_data[j] is final (0 for a load still in flight).
REQ-018 Port flush  in  1  kill the instruction being captured (branch/jump).
REQ-019 Port hold  in  1  downstream back-pressure; keep current contents.
REQ-020 Port out_valid  out  1; out_ctrl  out  CTRLW; out_pc, out_imm  out  XLEN; out_rd  out  5; out_rs_data  out  NSRC*XLEN  registered stage outputs.
REQ-021 Port stall_req  out  1  combinational load-use stall request to upstream.

Function
REQ-022 Match(i,j) SHALL be true when fwd_en[j]=1, fwd_rd[j]!=0 and fwd_rd[j] equals the operand-i address; x0 never forwards.
REQ-023 Operand i resolved value SHALL be fwd_data[j] for the lowest j with Match(i,j), else in_rs_data[i]; the youngest source always wins over older ones.
REQ-024 stall_req SHALL be 1 when in_valid=1, flush=0 and, for any operand, the winning match j has fwd_rdy[j]=0.
REQ-025 Priority per cycle SHALL be: flush > hold > stall_req > normal load.
REQ-026 flush=1: out_valid<=0, out_ctrl<=0, out_rd<=0 next edge, regardless of hold; other outputs are don't-care.
REQ-027 hold=1 (no flush): all outputs keep their values, except each out_rs_data[i] SHALL be updated by snooping: if the stored operand address (kept internally) matches a source j per REQ-022/023 with fwd_rdy[j]=1, it loads fwd_data[j].
REQ-028 stall_req=1 (no flush/hold): bubble inserted — out_valid<=0, out_ctrl<=0, out_rd<=0; upstream must hold its inputs.
REQ-029 Normal load: all outputs capture inputs with resolved operand values; latency 1 cycle.
REQ-030 in_valid=0 on normal load SHALL capture out_valid=0 and out_ctrl=0.
REQ-031 No X-propagation tests on data; selection depends only on en/rd/rdy.

Reset
REQ-032 reset=0 SHALL immediately clear out_valid, out_ctrl, out_pc, out_imm, out_rd, out_rs_data and stored operand addresses to 0, overriding any in-flight hold/flush.
REQ-033 First rising edge after reset release SHALL perform a normal load.

Verification
REQ-034 rs1=5, in_rs_data=0x11, fwd0 rd=5 data=0xAA rdy=1, fwd1 rd=5 data=0xBB -> out_rs_data[0]=0xAA after one edge.
REQ-035 rs2=0, fwd0 rd=0 en=1 data=0xFF, in_rs_data[1]=0x0 -> out_rs_data[1]=0x0.
REQ-036 rs1=7, fwd0 rd=7 rdy=0 -> stall_req=1 same cycle, next out_valid=0; next cycle fwd1 rd=7 rdy=1 data=0x42 -> out_rs_data[0]=0x42, out_valid=1.
REQ-037 hold=1 three cycles with stored rs1=9, fwd1 rd=9 data=0x77 rdy=1 in cycle 2 -> out_pc unchanged, out_rs_data[0]=0x77 from cycle 3.
REQ-038 flush=1 and hold=1 together -> out_valid=0, out_ctrl=0 next edge.
REQ-039 reset asserted mid-hold with out_valid=1 -> all outputs 0 without a clock edge.
